// File: rtl/tl_pkg.sv
// Shared light codes, controller state codes and helpers for the two-road traffic light.
package tl_pkg;

   localparam int PHASE_W = 3;

   localparam logic [1:0] LIGHT_GREEN  = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_LEFT   = 2'b10;
   localparam logic [1:0] LIGHT_RED    = 2'b11;

   typedef enum logic [PHASE_W-1:0] {
      AG  = 3'd0,
      AY  = 3'd1,
      AL  = 3'd2,
      ALY = 3'd3,
      BG  = 3'd4,
      BY  = 3'd5,
      BL  = 3'd6,
      BLY = 3'd7
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase dwell timer: synchronous clear, count enable, saturates at all-ones.
module tl_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tl_cntr_param.sv
// Two-road traffic light controller with sensor-driven handover and optional left-turn
// arrows (left-arrow phases and left-turn requests exist only when TL_LEFT_EN is defined).
module tl_cntr_param
   import tl_pkg::*;
#(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 2,
   parameter int LEFT_T    = 3,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Ta,
   input  logic               Tb,
   input  logic               Tal,
   input  logic               Tbl,
   output logic [1:0]         La,
   output logic [1:0]         Lb,
   output logic [PHASE_W-1:0] phase
);

   localparam int LONGEST = max3(GREEN_MAX, YELLOW_T, LEFT_T);

   if ((CNT_W < 1) || ((CNT_W < 32) && ((64'd1 << CNT_W) < 64'(LONGEST)))) begin : g_cnt_w_check
      $error("tl_cntr_param: CNT_W too narrow for the longest phase dwell");
   end

   localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] T_L    = CNT_W'(LEFT_T - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] timer;
   logic             demand_a;
   logic             demand_b;
   logic             go_al;
   logic             go_bl;

`ifdef TL_LEFT_EN
   logic req_al;
   logic req_bl;

   // Entering the arrow consumes the request; a sensor hit on that same cycle is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_al <= 1'b0;
         req_bl <= 1'b0;
      end else begin
         if ((state != AL) && (next_state == AL))
            req_al <= 1'b0;
         else if (Tal && (state != AL) && (state != ALY))
            req_al <= 1'b1;

         if ((state != BL) && (next_state == BL))
            req_bl <= 1'b0;
         else if (Tbl && (state != BL) && (state != BLY))
            req_bl <= 1'b1;
      end
   end

   assign demand_a = Ta | Tal | req_al;
   assign demand_b = Tb | Tbl | req_bl;
   assign go_al    = req_al;
   assign go_bl    = req_bl;
`else
   logic unused_left;

   assign unused_left = Tal | Tbl;
   assign demand_a    = Ta;
   assign demand_b    = Tb;
   assign go_al       = 1'b0;
   assign go_bl       = 1'b0;
`endif

   tl_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (next_state != state),
      .enable (1'b1),
      .count  (timer)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= AG;
      else
         state <= next_state;
   end

   // Green yields early once the min dwell is met and its own road is empty,
   // and is forced over at the max dwell while the cross road still waits.
   always_comb begin
      next_state = state;
      case (state)
         AG:  if (demand_b && (((timer >= T_GMIN) && !Ta) || (timer == T_GMAX))) next_state = AY;
         AY:  if (timer == T_Y) next_state = go_al ? AL : BG;
         AL:  if (timer == T_L) next_state = ALY;
         ALY: if (timer == T_Y) next_state = BG;
         BG:  if (demand_a && (((timer >= T_GMIN) && !Tb) || (timer == T_GMAX))) next_state = BY;
         BY:  if (timer == T_Y) next_state = go_bl ? BL : AG;
         BL:  if (timer == T_L) next_state = BLY;
         BLY: if (timer == T_Y) next_state = AG;
         default: next_state = AG;
      endcase
   end

   always_comb begin
      La = LIGHT_RED;
      Lb = LIGHT_RED;
      case (state)
         AG:       La = LIGHT_GREEN;
         AY, ALY:  La = LIGHT_YELLOW;
         BG:       Lb = LIGHT_GREEN;
         BY, BLY:  Lb = LIGHT_YELLOW;
`ifdef TL_LEFT_EN
         AL:       La = LIGHT_LEFT;
         BL:       Lb = LIGHT_LEFT;
`endif
         default: begin
            La = LIGHT_RED;
            Lb = LIGHT_RED;
         end
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_tl_cntr_param.sv
// Bench for tl_cntr_param: directed scenarios plus random sensors against a cycle model.
module tb_tl_cntr_param;

   localparam int GMIN = 4;
   localparam int GMAX = 10;
   localparam int YT   = 2;
   localparam int LT   = 3;
`ifdef TL_LEFT_EN
   localparam bit LEFT_ON = 1'b1;
`else
   localparam bit LEFT_ON = 1'b0;
`endif

   localparam logic [1:0] C_GREEN  = 2'd0;
   localparam logic [1:0] C_YELLOW = 2'd1;
   localparam logic [1:0] C_LEFT   = 2'd2;
   localparam logic [1:0] C_RED    = 2'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic       Ta, Tb, Tal, Tbl;
   logic [1:0] La, Lb;
   logic [2:0] phase;

   int total = 0;
   int bad   = 0;

   // Model: phase number, cycles already spent in it, pending left requests.
   int m_state;
   int m_dwell;
   bit m_ral;
   bit m_rbl;

   always #5 clk = ~clk;

   tl_cntr_param #(
      .GREEN_MIN (GMIN),
      .GREEN_MAX (GMAX),
      .YELLOW_T  (YT),
      .LEFT_T    (LT),
      .CNT_W     (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .Ta    (Ta),
      .Tb    (Tb),
      .Tal   (Tal),
      .Tbl   (Tbl),
      .La    (La),
      .Lb    (Lb),
      .phase (phase)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_lights(input int s);
      case (s)
         0:       return {C_GREEN,  C_RED};
         1, 3:    return {C_YELLOW, C_RED};
         2:       return {C_LEFT,   C_RED};
         4:       return {C_RED,    C_GREEN};
         5, 7:    return {C_RED,    C_YELLOW};
         6:       return {C_RED,    C_LEFT};
         default: return {C_RED,    C_RED};
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_dwell = 0;
      m_ral   = 1'b0;
      m_rbl   = 1'b0;
   endtask

   // One clock of the model, from the inputs held across the coming edge.
   task automatic model_step();
      int nxt;
      bit dem_a, dem_b;
      nxt   = m_state;
      dem_a = Ta | (LEFT_ON & (Tal | m_ral));
      dem_b = Tb | (LEFT_ON & (Tbl | m_rbl));
      case (m_state)
         0: if (dem_b && ((m_dwell >= GMIN - 1 && !Ta) || m_dwell == GMAX - 1)) nxt = 1;
         1: if (m_dwell == YT - 1) nxt = (LEFT_ON && m_ral) ? 2 : 4;
         2: if (m_dwell == LT - 1) nxt = 3;
         3: if (m_dwell == YT - 1) nxt = 4;
         4: if (dem_a && ((m_dwell >= GMIN - 1 && !Tb) || m_dwell == GMAX - 1)) nxt = 5;
         5: if (m_dwell == YT - 1) nxt = (LEFT_ON && m_rbl) ? 6 : 0;
         6: if (m_dwell == LT - 1) nxt = 7;
         7: if (m_dwell == YT - 1) nxt = 0;
         default: nxt = 0;
      endcase
      if (LEFT_ON) begin
         if (m_state != 2 && nxt == 2) m_ral = 1'b0;
         else if (Tal && m_state != 2 && m_state != 3) m_ral = 1'b1;
         if (m_state != 6 && nxt == 6) m_rbl = 1'b0;
         else if (Tbl && m_state != 6 && m_state != 7) m_rbl = 1'b1;
      end
      m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
      m_state = nxt;
   endtask

   task automatic compare(input string tag);
      logic [3:0] lt;
      lt = model_lights(m_state);
      check({tag, "_phase"}, 8'(phase), 8'(m_state));
      check({tag, "_La"}, 8'(La), 8'(lt[3:2]));
      check({tag, "_Lb"}, 8'(Lb), 8'(lt[1:0]));
      check({tag, "_one_red"}, 8'((La == C_RED) || (Lb == C_RED)), 8'd1);
   endtask

   task automatic drive(input logic a, input logic b, input logic al, input logic bl);
      Ta  = a;
      Tb  = b;
      Tal = al;
      Tbl = bl;
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   // Asserted between edges so the light change must not wait for a clock.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_La", 8'(La), 8'(C_GREEN));
      check("rst_Lb", 8'(Lb), 8'(C_RED));
      check("rst_phase", 8'(phase), 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   int left_cycles;
   bit found;

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0);

      // Idle: no sensors means green on A forever.
      do_reset();
      for (int i = 0; i < 50; i++) tick("idle");
      check("idle_end_phase", 8'(phase), 8'd0);

      // B traffic only: 4 cycles AG, 2 cycles AY, then BG.
      do_reset();
      drive(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) tick("b_only");
      check("b_only_ag4", 8'(phase), 8'd0);
      tick("b_only");
      check("b_only_ay1", 8'(phase), 8'd1);
      tick("b_only");
      check("b_only_ay2", 8'(phase), 8'd1);
      tick("b_only");
      check("b_only_bg", 8'(phase), 8'd4);
      check("b_only_bg_La", 8'(La), 8'(C_RED));
      check("b_only_bg_Lb", 8'(Lb), 8'(C_GREEN));
      for (int i = 0; i < 10; i++) tick("b_only_hold");

      // Both roads busy: forced handover at the max dwell each way.
      do_reset();
      drive(1, 1, 0, 0);
      for (int i = 0; i < 9; i++) tick("both");
      check("both_ag10", 8'(phase), 8'd0);
      tick("both");
      check("both_ay", 8'(phase), 8'd1);
      for (int i = 0; i < 50; i++) tick("both");

      // One-cycle left request on A, then B traffic: a single arrow cycle.
      do_reset();
      drive(0, 0, 1, 0);
      tick("left_a");
      drive(0, 1, 0, 0);
      left_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         tick("left_a");
         if (La == C_LEFT) left_cycles++;
      end
      check("left_a_cycles", 8'(left_cycles), LEFT_ON ? 8'(LT) : 8'd0);
      check("left_a_end_bg", 8'(phase), 8'd4);

      // Reset during the first cycle of BY, then a clean 4-cycle AG.
      do_reset();
      drive(1, 1, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick("to_by");
         if (m_state == 5 && m_dwell == 0) found = 1'b1;
      end
      check("reach_by", 8'(phase), 8'd5);
      do_reset();
      drive(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) tick("post_rst");
      check("post_rst_ag4", 8'(phase), 8'd0);
      tick("post_rst");
      check("post_rst_ay", 8'(phase), 8'd1);

      // Left sensors held with B traffic: arrow only when enabled.
      do_reset();
      drive(0, 1, 1, 1);
      left_cycles = 0;
      for (int i = 0; i < 30; i++) begin
         tick("left_hold");
         if (La == C_LEFT || Lb == C_LEFT) left_cycles++;
      end
      if (!LEFT_ON) check("no_left_code", 8'(left_cycles), 8'd0);

      // Random sensors with rare resets.
      do_reset();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 9) == 0) Ta = ~Ta;
         if ($urandom_range(0, 9) == 0) Tb = ~Tb;
         Tal = ($urandom_range(0, 11) == 0);
         Tbl = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
